// File: rtl/id_stage_pipe_if.sv
// ID/EX output bus: the registered decode result plus its valid/ready handshake.
// The decode stage drives it as master; the execute stage consumes it as slave.
interface id_stage_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                out_valid;
    logic                out_ready;
    logic [ALUOP_W-1:0]  aluop_o;
    logic [ALUSEL_W-1:0] alusel_o;
    logic [DATA_W-1:0]   reg1_o;
    logic [DATA_W-1:0]   reg2_o;
    logic [RADDR_W-1:0]  wd_o;
    logic                wreg_o;
    logic [31:0]         pc_o;
    logic                instvalid_o;

    modport master (
        output out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, instvalid_o,
        input  out_ready
    );

    modport slave (
        input  out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, instvalid_o,
        output out_ready
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage for the logic/shift instruction subset with an integrated ID/EX
// register. Operands come from the regfile or from NUM_FWD forwarding sources
// (index 0 youngest, highest priority); a load still in flight on a needed
// source stalls the stage and inserts a bubble towards EX.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    // IF side
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                pc_i,
    input  logic [31:0]                inst_i,
    // regfile read ports
    output logic                       reg1_read_o,
    output logic [RADDR_W-1:0]         reg1_addr_o,
    input  logic [DATA_W-1:0]          reg1_data_i,
    output logic                       reg2_read_o,
    output logic [RADDR_W-1:0]         reg2_addr_o,
    input  logic [DATA_W-1:0]          reg2_data_i,
    // forwarding sources
    input  logic [NUM_FWD-1:0]         fwd_wreg_i,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
    input  logic [NUM_FWD-1:0]         fwd_load_i,
    input  logic                       flush_i,
    // EX side
    id_stage_pipe_if.master            ex_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    // Opcode / function fields
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SYNC = 6'b001111;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // EXE_*_OP codes
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

    // EXE_RES_* codes
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    // Instruction fields
    logic [5:0]         op;
    logic [5:0]         fn;
    logic [4:0]         sa;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    logic [15:0]        imm16;

    assign op    = inst_i[31:26];
    assign fn    = inst_i[5:0];
    assign sa    = inst_i[10:6];
    assign rs    = RADDR_W'(inst_i[25:21]);
    assign rt    = RADDR_W'(inst_i[20:16]);
    assign rd    = RADDR_W'(inst_i[15:11]);
    assign imm16 = inst_i[15:0];

    // Decode results feeding the ID/EX register
    logic [7:0]         aluop_d;
    logic [2:0]         alusel_d;
    logic [RADDR_W-1:0] wd_d;
    logic               wreg_d;
    logic               instvalid_d;
    logic               read1_d;
    logic               read2_d;
    logic [DATA_W-1:0]  imm_d;
    logic [DATA_W-1:0]  reg1_d;
    logic [DATA_W-1:0]  reg2_d;

    // ID/EX register
    logic               out_valid_q;
    logic [7:0]         aluop_q;
    logic [2:0]         alusel_q;
    logic [DATA_W-1:0]  reg1_q;
    logic [DATA_W-1:0]  reg2_q;
    logic [RADDR_W-1:0] wd_q;
    logic               wreg_q;
    logic [31:0]        pc_q;
    logic               instvalid_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    // Instruction decode: control fields, read enables and immediate
    always_comb begin
        aluop_d     = EXE_NOP_OP;
        alusel_d    = EXE_RES_NOP;
        wd_d        = rd;
        wreg_d      = 1'b0;
        instvalid_d = 1'b0;
        read1_d     = 1'b0;
        read2_d     = 1'b0;
        imm_d       = '0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                        if (sa == 5'd0) begin
                            instvalid_d = 1'b1;
                            wreg_d      = 1'b1;
                            read1_d     = 1'b1;
                            read2_d     = 1'b1;
                            alusel_d    = EXE_RES_LOGIC;
                            case (fn)
                                FN_OR:   aluop_d = EXE_OR_OP;
                                FN_AND:  aluop_d = EXE_AND_OP;
                                FN_XOR:  aluop_d = EXE_XOR_OP;
                                default: aluop_d = EXE_NOR_OP;
                            endcase
                        end
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        if (sa == 5'd0) begin
                            instvalid_d = 1'b1;
                            wreg_d      = 1'b1;
                            read1_d     = 1'b1;
                            read2_d     = 1'b1;
                            alusel_d    = EXE_RES_SHIFT;
                            case (fn)
                                FN_SLLV: aluop_d = EXE_SLL_OP;
                                FN_SRLV: aluop_d = EXE_SRL_OP;
                                default: aluop_d = EXE_SRA_OP;
                            endcase
                        end
                    end
                    FN_SYNC: begin
                        // Memory barrier: nothing to do in this pipeline
                        if (sa == 5'd0) begin
                            instvalid_d = 1'b1;
                        end
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shift amount comes from sa, so the rs field must be zero
                        if (inst_i[25:21] == 5'd0) begin
                            instvalid_d = 1'b1;
                            wreg_d      = 1'b1;
                            read2_d     = 1'b1;
                            imm_d       = DATA_W'(sa);
                            alusel_d    = EXE_RES_SHIFT;
                            case (fn)
                                FN_SLL:  aluop_d = EXE_SLL_OP;
                                FN_SRL:  aluop_d = EXE_SRL_OP;
                                default: aluop_d = EXE_SRA_OP;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                instvalid_d = 1'b1;
                wreg_d      = 1'b1;
                wd_d        = rt;
                read1_d     = 1'b1;
                alusel_d    = EXE_RES_LOGIC;
                imm_d       = DATA_W'(imm16);
                case (op)
                    OP_ANDI: aluop_d = EXE_AND_OP;
                    OP_XORI: aluop_d = EXE_XOR_OP;
                    OP_LUI: begin
                        aluop_d = EXE_OR_OP;
                        imm_d   = DATA_W'({imm16, 16'h0000});
                    end
                    default: aluop_d = EXE_OR_OP;
                endcase
            end
            OP_PREF: begin
                // Prefetch hint is accepted but has no effect
                instvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg1_read_o = read1_d;
    assign reg2_read_o = read2_d;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    // Per read port: find the winning forwarding source and resolve the operand.
    // Port 0 uses rs / regfile port 1, port 1 uses rt / regfile port 2.
    logic [1:0]        port_hazard;
    logic [DATA_W-1:0] port_data [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [RADDR_W-1:0] addr;
            logic               rd_en;
            logic [DATA_W-1:0]  rf_data;
            logic               hit;
            logic               hit_load;
            logic [DATA_W-1:0]  hit_data;

            assign addr    = (gi == 0) ? rs : rt;
            assign rd_en   = (gi == 0) ? read1_d : read2_d;
            assign rf_data = (gi == 0) ? reg1_data_i : reg2_data_i;

            // Scan from oldest to youngest so the lowest matching index wins
            always_comb begin
                hit      = 1'b0;
                hit_load = 1'b0;
                hit_data = '0;
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wreg_i[k] && (fwd_wd_i[k*RADDR_W +: RADDR_W] == addr)) begin
                        hit      = 1'b1;
                        hit_load = fwd_load_i[k];
                        hit_data = fwd_wdata_i[k*DATA_W +: DATA_W];
                    end
                end
            end

            // $0 is hardwired zero and never forwarded; unread ports carry the immediate
            always_comb begin
                port_hazard[gi] = 1'b0;
                if (!rd_en) begin
                    port_data[gi] = imm_d;
                end else if (addr == '0) begin
                    port_data[gi] = '0;
                end else if (hit) begin
                    port_data[gi]   = hit_data;
                    port_hazard[gi] = hit_load;
                end else begin
                    port_data[gi] = rf_data;
                end
            end
        end
    endgenerate

    assign reg1_d = port_data[0];
    assign reg2_d = port_data[1];

    logic hazard;
    logic accept;

    assign hazard   = |port_hazard;
    assign in_ready = rst && !flush_i && !hazard && (!out_valid_q || ex_o.out_ready);
    assign accept   = in_valid && in_ready;

    // ID/EX register: flush, then accept, then drain to a bubble, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= EXE_NOP_OP;
            alusel_q    <= EXE_RES_NOP;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            pc_q        <= '0;
            instvalid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_i;
            instvalid_q <= instvalid_d;
        end else if (ex_o.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Load-use stall counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (in_valid && hazard && !flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign ex_o.out_valid   = out_valid_q;
    assign ex_o.aluop_o     = aluop_q;
    assign ex_o.alusel_o    = alusel_q;
    assign ex_o.reg1_o      = reg1_q;
    assign ex_o.reg2_o      = reg2_q;
    assign ex_o.wd_o        = wd_q;
    assign ex_o.wreg_o      = wreg_q;
    assign ex_o.pc_o        = pc_q;
    assign ex_o.instvalid_o = instvalid_q;
    assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: forwarding, priority, decode, load-use
// stall, back-pressure, flush and asynchronous reset.
module tb_id_stage_pipe;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_SLL = 8'h7C;
    localparam logic [2:0] RES_LOGIC = 3'd1;
    localparam logic [2:0] RES_SHIFT = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i = '0;
    logic [9:0]  fwd_wd_i = '0;
    logic [63:0] fwd_wdata_i = '0;
    logic [1:0]  fwd_load_i = '0;
    logic        flush_i = 1'b0;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    id_stage_pipe_if #(.DATA_W(32), .RADDR_W(5)) ex_if ();

    id_stage_pipe #(.DATA_W(32), .RADDR_W(5), .NUM_FWD(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
        .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_load_i(fwd_load_i), .flush_i(flush_i),
        .ex_o(ex_if), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Regfile model: register n reads 0xA500_00nn (even $0, which the DUT must force to 0)
    assign reg1_data_i = {8'hA5, 19'd0, reg1_addr_o};
    assign reg2_data_i = {8'hA5, 19'd0, reg2_addr_o};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] p);
        inst_i = ins; pc_i = p; in_valid = 1'b1;
    endtask

    task automatic no_fwd();
        fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_load_i = '0;
    endtask

    task automatic test_reset();
        ex_if.out_ready = 1'b1;
        put(32'h34011100, 32'h4);
        tick();
        checks++; if (ex_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_if.out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if ({ex_if.aluop_o, ex_if.alusel_o, ex_if.reg1_o, ex_if.reg2_o, ex_if.pc_o} !== '0)
            begin errors++; $display("FAIL reset_regs got nonzero aluop %h reg1 %h reg2 %h pc %h", ex_if.aluop_o, ex_if.reg1_o, ex_if.reg2_o, ex_if.pc_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt_o); end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_fwd_basic();
        no_fwd();
        put(32'h34011100, 32'h100);                  // ori $1,$0,0x1100
        tick();
        $display("txn ori pc=%h reg1=%h reg2=%h wd=%0d", ex_if.pc_o, ex_if.reg1_o, ex_if.reg2_o, ex_if.wd_o);
        checks++; if (ex_if.out_valid !== 1'b1) begin errors++; $display("FAIL ori_valid got %b exp 1", ex_if.out_valid); end
        checks++; if (ex_if.reg2_o !== 32'h1100 || ex_if.reg1_o !== 32'h0) begin errors++; $display("FAIL ori_ops got %h/%h exp 0/1100", ex_if.reg1_o, ex_if.reg2_o); end
        checks++; if (ex_if.wd_o !== 5'd1 || ex_if.wreg_o !== 1'b1 || ex_if.aluop_o !== OP_OR || ex_if.alusel_o !== RES_LOGIC)
            begin errors++; $display("FAIL ori_ctrl got wd %0d wreg %b aluop %h alusel %0d", ex_if.wd_o, ex_if.wreg_o, ex_if.aluop_o, ex_if.alusel_o); end
        put(32'h00211025, 32'h104);                  // or $2,$1,$1, EX forwards $1
        fwd_wreg_i = 2'b01; fwd_wd_i[4:0] = 5'd1; fwd_wdata_i[31:0] = 32'h1100;
        tick();
        $display("txn or pc=%h reg1=%h reg2=%h wd=%0d", ex_if.pc_o, ex_if.reg1_o, ex_if.reg2_o, ex_if.wd_o);
        checks++; if (ex_if.reg1_o !== 32'h1100 || ex_if.reg2_o !== 32'h1100) begin errors++; $display("FAIL or_fwd got %h/%h exp 1100/1100", ex_if.reg1_o, ex_if.reg2_o); end
        checks++; if (ex_if.wd_o !== 5'd2 || ex_if.pc_o !== 32'h104) begin errors++; $display("FAIL or_wd got wd %0d pc %h exp 2 104", ex_if.wd_o, ex_if.pc_o); end
    endtask

    task automatic test_fwd_priority();
        put(32'h00603824, 32'h108);                  // and $7,$3,$0
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd3, 5'd3}; fwd_wdata_i = {32'hB, 32'hA};
        tick();
        $display("txn and pc=%h reg1=%h reg2=%h", ex_if.pc_o, ex_if.reg1_o, ex_if.reg2_o);
        checks++; if (ex_if.reg1_o !== 32'hA) begin errors++; $display("FAIL prio_reg1 got %h exp a", ex_if.reg1_o); end
        checks++; if (ex_if.reg2_o !== 32'h0) begin errors++; $display("FAIL zero_reg2 got %h exp 0", ex_if.reg2_o); end
        put(32'h00034025, 32'h10C);                  // or $8,$0,$3; fwd0 targets $0
        fwd_wd_i = {5'd3, 5'd0}; fwd_wdata_i = {32'hB, 32'hDEAD};
        tick();
        $display("txn or pc=%h reg1=%h reg2=%h", ex_if.pc_o, ex_if.reg1_o, ex_if.reg2_o);
        checks++; if (ex_if.reg1_o !== 32'h0) begin errors++; $display("FAIL zero_nofwd got %h exp 0", ex_if.reg1_o); end
        checks++; if (ex_if.reg2_o !== 32'hB) begin errors++; $display("FAIL fwd1_reg2 got %h exp b", ex_if.reg2_o); end
        no_fwd();
        put(32'h00854825, 32'h110);                  // or $9,$4,$5 from regfile
        tick();
        $display("txn or pc=%h reg1=%h reg2=%h", ex_if.pc_o, ex_if.reg1_o, ex_if.reg2_o);
        checks++; if (ex_if.reg1_o !== 32'hA5000004 || ex_if.reg2_o !== 32'hA5000005)
            begin errors++; $display("FAIL rf_ops got %h/%h exp a5000004/a5000005", ex_if.reg1_o, ex_if.reg2_o); end
    endtask

    task automatic test_decode();
        put(32'h3C048000, 32'h200);                  // lui $4,0x8000
        tick();
        $display("txn lui reg2=%h wd=%0d", ex_if.reg2_o, ex_if.wd_o);
        checks++; if (ex_if.reg2_o !== 32'h80000000 || ex_if.wd_o !== 5'd4 || ex_if.aluop_o !== OP_OR)
            begin errors++; $display("FAIL lui got reg2 %h wd %0d aluop %h", ex_if.reg2_o, ex_if.wd_o, ex_if.aluop_o); end
        put(32'h00062900, 32'h204);                  // sll $5,$6,4
        tick();
        $display("txn sll reg1=%h reg2=%h wd=%0d", ex_if.reg1_o, ex_if.reg2_o, ex_if.wd_o);
        checks++; if (ex_if.reg1_o !== 32'd4 || ex_if.reg2_o !== 32'hA5000006 || ex_if.wd_o !== 5'd5)
            begin errors++; $display("FAIL sll_ops got reg1 %h reg2 %h wd %0d", ex_if.reg1_o, ex_if.reg2_o, ex_if.wd_o); end
        checks++; if (ex_if.aluop_o !== OP_SLL || ex_if.alusel_o !== RES_SHIFT) begin errors++; $display("FAIL sll_ctrl got %h/%0d exp 7c/2", ex_if.aluop_o, ex_if.alusel_o); end
        put(32'hFC000000, 32'h208);                  // opcode 0x3F
        tick();
        $display("txn op3f instvalid=%b wreg=%b", ex_if.instvalid_o, ex_if.wreg_o);
        checks++; if (ex_if.instvalid_o !== 1'b0 || ex_if.wreg_o !== 1'b0 || ex_if.aluop_o !== OP_NOP)
            begin errors++; $display("FAIL op3f got instvalid %b wreg %b aluop %h", ex_if.instvalid_o, ex_if.wreg_o, ex_if.aluop_o); end
        put(32'h00211065, 32'h20C);                  // or with sa=1: reserved
        tick();
        checks++; if (ex_if.instvalid_o !== 1'b0 || ex_if.wreg_o !== 1'b0) begin errors++; $display("FAIL or_sa got instvalid %b wreg %b exp 0 0", ex_if.instvalid_o, ex_if.wreg_o); end
        put(32'h0000000F, 32'h210);                  // sync
        tick();
        $display("txn sync instvalid=%b wreg=%b", ex_if.instvalid_o, ex_if.wreg_o);
        checks++; if (ex_if.instvalid_o !== 1'b1 || ex_if.wreg_o !== 1'b0 || ex_if.aluop_o !== OP_NOP)
            begin errors++; $display("FAIL sync got instvalid %b wreg %b aluop %h", ex_if.instvalid_o, ex_if.wreg_o, ex_if.aluop_o); end
    endtask

    task automatic test_load_use();
        put(32'h00645024, 32'h300);                  // and $10,$3,$4, $3 still loading
        fwd_wreg_i = 2'b01; fwd_wd_i[4:0] = 5'd3; fwd_wdata_i[31:0] = 32'h55; fwd_load_i = 2'b01;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready got %b exp 0", in_ready); end
        tick();
        $display("txn load-use bubble valid=%b stall=%0d", ex_if.out_valid, stall_cnt_o);
        checks++; if (ex_if.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble got %b exp 0", ex_if.out_valid); end
        checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt_o); end
        fwd_load_i = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL retry_ready got %b exp 1", in_ready); end
        tick();
        $display("txn and retry reg1=%h reg2=%h", ex_if.reg1_o, ex_if.reg2_o);
        checks++; if (ex_if.out_valid !== 1'b1 || ex_if.reg1_o !== 32'h55 || ex_if.reg2_o !== 32'hA5000004)
            begin errors++; $display("FAIL retry got valid %b reg1 %h reg2 %h", ex_if.out_valid, ex_if.reg1_o, ex_if.reg2_o); end
        checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_hold got %0d exp 1", stall_cnt_o); end
        no_fwd();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b0;
        tick();                                      // drain
        ex_if.out_ready = 1'b0;
        put(32'h00854825, 32'h400);
        tick();
        put(32'h00854825, 32'h404);
        for (int i = 0; i < 3; i++) begin
            checks++; if (ex_if.out_valid !== 1'b1 || ex_if.pc_o !== 32'h400 || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d got valid %b pc %h ready %b", i, ex_if.out_valid, ex_if.pc_o, in_ready); end
            tick();
        end
        ex_if.out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", in_ready); end
        tick();
        $display("txn release pc=%h", ex_if.pc_o);
        checks++; if (ex_if.pc_o !== 32'h404) begin errors++; $display("FAIL release_pc got %h exp 404", ex_if.pc_o); end
        put(32'h00854825, 32'h408);
        tick();
        $display("txn back-to-back pc=%h", ex_if.pc_o);
        checks++; if (ex_if.pc_o !== 32'h408 || ex_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_pc got %h valid %b exp 408 1", ex_if.pc_o, ex_if.out_valid); end
    endtask

    task automatic test_flush();
        ex_if.out_ready = 1'b0;
        put(32'h34011100, 32'h500);
        flush_i = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        tick();
        $display("txn flush valid=%b", ex_if.out_valid);
        checks++; if (ex_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ex_if.out_valid); end
        flush_i = 1'b0;
        ex_if.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        put(32'h00211025, 32'h600);
        fwd_wreg_i = 2'b01; fwd_wd_i[4:0] = 5'd1; fwd_wdata_i[31:0] = 32'h77;
        tick();
        checks++; if (ex_if.out_valid !== 1'b1 || ex_if.reg1_o !== 32'h77) begin errors++; $display("FAIL pre_reset got valid %b reg1 %h", ex_if.out_valid, ex_if.reg1_o); end
        #2 rst = 1'b0;
        #1;
        $display("txn async reset valid=%b stall=%0d", ex_if.out_valid, stall_cnt_o);
        checks++; if (ex_if.out_valid !== 1'b0 || ex_if.reg1_o !== '0 || ex_if.wd_o !== '0 || ex_if.pc_o !== '0 || ex_if.wreg_o !== 1'b0)
            begin errors++; $display("FAIL async_reset got valid %b reg1 %h wd %0d pc %h", ex_if.out_valid, ex_if.reg1_o, ex_if.wd_o, ex_if.pc_o); end
        checks++; if (stall_cnt_o !== 16'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_reset_cnt got stall %0d ready %b", stall_cnt_o, in_ready); end
        in_valid = 1'b0;
        no_fwd();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_fwd_priority();
        test_decode();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
